// File: rtl/riscv_defines_pkg.sv
// Shared RISC-V machine-mode definitions: trap packets, cause codes, CSR
// addresses, mstatus bit positions and the CSR read-modify-write helper.
package riscv_defines;

  typedef enum logic {
    TRAP_ENTER  = 1'b0,
    TRAP_RETURN = 1'b1
  } trap_mode_t;

  localparam int CAUSE_W = 5;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_FETCH = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR    = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_MMODE      = 5'd11;

  typedef struct packed {
    logic               valid;
    trap_mode_t         mode;
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        pc;
    logic [31:0]        tval;
  } trap_req_t;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_t;

  typedef enum logic {
    TS_IDLE     = 1'b0,
    TS_REDIRECT = 1'b1
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_RS:  return old | wdata;
      CSR_RC:  return old & ~wdata;
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/trap_csr_unit_counter64.sv
// 64-bit CSR counter; a write to either half replaces that half and holds the
// other half, taking priority over the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (we_lo) begin
      count_reg[31:0] <= wdata;
    end else if (we_hi) begin
      count_reg[63:32] <= wdata;
    end else if (inc) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign value = count_reg;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap responder and CSR file at the commit boundary: captures
// trap state, issues a one-cycle redirect with flush, and serves CSR accesses.
module trap_csr_unit
  import riscv_defines::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  trap_req_t   trap_req,
  input  logic        retire,
  input  logic        csr_valid,
  input  logic        csr_we,
  input  csr_op_t     csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_req,
  output logic        trap_busy
);

  trap_state_t state_reg, state_next;
  logic [31:0] redirect_pc_reg;
  logic        mie_reg, mpie_reg;
  logic [31:0] mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_val, wr_val;
  logic        csr_mapped, trap_accept, wr_en;

  assign trap_accept = (state_reg == TS_IDLE) && trap_req.valid && !rst;

  always_comb begin
    state_next     = state_reg;
    redirect_valid = 1'b0;
    trap_busy      = 1'b0;
    case (state_reg)
      TS_IDLE:     if (trap_req.valid) state_next = TS_REDIRECT;
      TS_REDIRECT: begin
        state_next     = TS_IDLE;
        redirect_valid = !rst;
        trap_busy      = !rst;
      end
      default:     state_next = TS_IDLE;
    endcase
    flush_req = trap_accept || redirect_valid;
  end

  always_comb begin
    mstatus_val                               = '0;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MPIE]                 = mpie_reg;
    mstatus_val[MSTATUS_MIE]                  = mie_reg;
  end

  always_comb begin
    csr_mapped = 1'b1;
    csr_rdata  = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_val;
      CSR_MISA:      csr_rdata = MISA_VAL;
      CSR_MTVEC:     csr_rdata = mtvec_reg;
      CSR_MSCRATCH:  csr_rdata = mscratch_reg;
      CSR_MEPC:      csr_rdata = mepc_reg;
      CSR_MCAUSE:    csr_rdata = mcause_reg;
      CSR_MTVAL:     csr_rdata = mtval_reg;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MHARTID:   csr_rdata = HART_ID;
      default:       csr_mapped = 1'b0;
    endcase
  end

  assign csr_illegal = csr_valid && (!csr_mapped || ((csr_addr[11:10] == 2'b11) && csr_we));
  // The CSR instruction is younger than a same-cycle trap and gets flushed.
  assign wr_en  = csr_valid && csr_we && !csr_illegal && !trap_accept;
  assign wr_val = csr_apply(csr_op, csr_rdata, csr_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= TS_IDLE;
      redirect_pc_reg <= '0;
      mie_reg         <= 1'b0;
      mpie_reg        <= 1'b0;
      mtvec_reg       <= '0;
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      mtval_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (trap_accept) begin
        if (trap_req.mode == TRAP_ENTER) begin
          mepc_reg        <= {trap_req.pc[31:2], 2'b00};
          mcause_reg      <= 32'(trap_req.cause);
          mtval_reg       <= trap_req.tval;
          mpie_reg        <= mie_reg;
          mie_reg         <= 1'b0;
          redirect_pc_reg <= {mtvec_reg[31:2], 2'b00};
        end else begin
          mie_reg         <= mpie_reg;
          mpie_reg        <= 1'b1;
          redirect_pc_reg <= mepc_reg;
        end
      end else if (wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_reg  <= wr_val[MSTATUS_MIE];
            mpie_reg <= wr_val[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec_reg    <= {wr_val[31:2], 2'b00};
          CSR_MSCRATCH: mscratch_reg <= wr_val;
          CSR_MEPC:     mepc_reg     <= {wr_val[31:2], 2'b00};
          CSR_MCAUSE:   mcause_reg   <= wr_val;
          CSR_MTVAL:    mtval_reg    <= wr_val;
          default: ;
        endcase
      end
    end
  end

  assign redirect_pc = redirect_pc_reg;

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (wr_en && (csr_addr == CSR_MCYCLE)),
    .we_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata (wr_val),
    .value (mcycle)
  );

  // The trapping instruction does not retire.
  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire && !trap_accept),
    .we_lo (wr_en && (csr_addr == CSR_MINSTRET)),
    .we_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata (wr_val),
    .value (minstret)
  );

endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: the driver predicts each cycle's outputs
// from a behavioural machine-mode model; a negedge monitor pops and compares.
module tb_trap_csr_unit;
  import riscv_defines::*;

  localparam logic [31:0] HART = 32'h0000_0005;
  localparam logic [31:0] MISA = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst;
  trap_req_t   trap_req;
  logic        retire, csr_valid, csr_we;
  csr_op_t     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, redirect_pc;
  logic        csr_illegal, redirect_valid, flush_req, trap_busy;

  trap_csr_unit #(.HART_ID(HART), .MISA_VAL(MISA)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .retire(retire),
    .csr_valid(csr_valid), .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_req(flush_req), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          tv;
    trap_mode_t  md;
    logic [4:0]  cause;
    logic [31:0] pc, tval;
    bit          ret, cv, we;
    csr_op_t     op;
    logic [11:0] a;
    logic [31:0] wd;
    bit          fx;     // override predicted rdata with a fixed constant
    logic [31:0] fv;
    bit          fpc;    // check redirect_pc against a fixed constant
    logic [31:0] fpcv;
    string       nm;
  } stim_t;

  typedef struct {
    bit          chk_csr;
    logic [31:0] rdata;
    bit          illegal;
    bit          rv, fl, busy;
    bit          chk_pc;
    logic [31:0] pc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Architectural model state
  bit          m_mie, m_mpie, m_pend;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_ppc;
  logic [63:0] m_cyc, m_ins;

  function automatic bit mread(input logic [11:0] a, output logic [31:0] v);
    v = 32'h0;
    case (a)
      12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: v = MISA;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF14: v = HART;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic stim_t blank(input string nm);
    stim_t s;
    s.rst = 0; s.tv = 0; s.md = TRAP_ENTER; s.cause = '0; s.pc = '0; s.tval = '0;
    s.ret = 0; s.cv = 0; s.we = 0; s.op = CSR_RW; s.a = '0; s.wd = '0;
    s.fx = 0; s.fv = '0; s.fpc = 0; s.fpcv = '0; s.nm = nm;
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [31:0] oldv, wv;
    logic [63:0] ncyc, nins;
    bit          mapped, accept;
    @(posedge clk);
    #1;
    rst = s.rst;
    trap_req.valid = s.tv; trap_req.mode = s.md; trap_req.cause = s.cause;
    trap_req.pc = s.pc; trap_req.tval = s.tval;
    retire = s.ret; csr_valid = s.cv; csr_we = s.we; csr_op = s.op;
    csr_addr = s.a; csr_wdata = s.wd;

    mapped    = mread(s.a, oldv);
    accept    = !s.rst && !m_pend && s.tv;
    e.nm      = s.nm;
    e.chk_csr = s.cv;
    e.rdata   = s.fx ? s.fv : oldv;
    e.illegal = s.cv && (!mapped || (s.a[11:10] == 2'b11 && s.we));
    e.rv      = !s.rst && m_pend;
    e.busy    = e.rv;
    e.fl      = accept || e.rv;
    e.chk_pc  = s.fpc || e.rv;
    e.pc      = s.fpc ? s.fpcv : m_ppc;
    exp_q.push_back(e);

    if (s.rst) begin
      m_mie = 0; m_mpie = 0; m_pend = 0; m_ppc = 0;
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cyc = 0; m_ins = 0;
    end else begin
      ncyc = m_cyc + 1;
      nins = m_ins + ((s.ret && !accept) ? 64'd1 : 64'd0);
      if (accept) begin
        if (s.md == TRAP_ENTER) begin
          m_mepc = s.pc & ~32'h3; m_mcause = 32'(s.cause); m_mtval = s.tval;
          m_mpie = m_mie; m_mie = 0; m_ppc = m_mtvec;
        end else begin
          m_mie = m_mpie; m_mpie = 1; m_ppc = m_mepc;
        end
      end else if (s.cv && s.we && !e.illegal) begin
        wv = (s.op == CSR_RS) ? (oldv | s.wd) : (s.op == CSR_RC) ? (oldv & ~s.wd) : s.wd;
        case (s.a)
          12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
          12'h305: m_mtvec = wv & ~32'h3;
          12'h340: m_mscratch = wv;
          12'h341: m_mepc = wv & ~32'h3;
          12'h342: m_mcause = wv;
          12'h343: m_mtval = wv;
          12'hB00: ncyc = {m_cyc[63:32], wv};
          12'hB80: ncyc = {wv, m_cyc[31:0]};
          12'hB02: nins = {m_ins[63:32], wv};
          12'hB82: nins = {wv, m_ins[31:0]};
          default: ;
        endcase
      end
      m_pend = accept;
      m_cyc  = ncyc;
      m_ins  = nins;
    end
  endtask

  task automatic idle(input string nm);
    cycle(blank(nm));
  endtask

  task automatic idle_pc(input string nm, input logic [31:0] pcv);
    stim_t s = blank(nm);
    s.fpc = 1; s.fpcv = pcv;
    cycle(s);
  endtask

  task automatic csr_acc(input string nm, input csr_op_t op, input logic [11:0] a,
                         input logic [31:0] wd, input bit we, input bit fx, input logic [31:0] fv);
    stim_t s = blank(nm);
    s.cv = 1; s.op = op; s.a = a; s.wd = wd; s.we = we; s.fx = fx; s.fv = fv;
    cycle(s);
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] fv);
    csr_acc(nm, CSR_RW, a, 32'h0, 1'b0, 1'b1, fv);
  endtask

  task automatic trap(input string nm, input trap_mode_t md, input logic [4:0] cause,
                      input logic [31:0] pc, input logic [31:0] tval);
    stim_t s = blank(nm);
    s.tv = 1; s.md = md; s.cause = cause; s.pc = pc; s.tval = tval; s.ret = 1;
    cycle(s);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.nm, ".redirect_valid"}, 32'(redirect_valid), 32'(e.rv));
        chk({e.nm, ".flush_req"}, 32'(flush_req), 32'(e.fl));
        chk({e.nm, ".trap_busy"}, 32'(trap_busy), 32'(e.busy));
        if (e.chk_pc) chk({e.nm, ".redirect_pc"}, redirect_pc, e.pc);
        if (e.chk_csr) begin
          chk({e.nm, ".csr_rdata"}, csr_rdata, e.rdata);
          chk({e.nm, ".csr_illegal"}, 32'(csr_illegal), 32'(e.illegal));
        end
        $display("txn %-16s rv=%0d fl=%0d busy=%0d rpc=%08h rdata=%08h ill=%0d", e.nm,
                 redirect_valid, flush_req, trap_busy, redirect_pc, csr_rdata, csr_illegal);
      end
    end
  end

  initial begin : driver
    stim_t s;
    logic [11:0] addrs [14];
    addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h344};
    rst = 1; trap_req = '0; retire = 0; csr_valid = 0; csr_we = 0;
    csr_op = CSR_RW; csr_addr = '0; csr_wdata = '0;

    for (int i = 0; i < 3; i++) begin
      s = blank("reset"); s.rst = 1; cycle(s);
    end
    rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd("rst_mepc", CSR_MEPC, 32'h0);
    idle_pc("rst_rpc", 32'h0);

    // Trap entry through mtvec with low bits masked
    csr_acc("wr_mtvec", CSR_RW, CSR_MTVEC, 32'h0000_0101, 1'b1, 1'b0, 32'h0);
    rd("rd_mtvec", CSR_MTVEC, 32'h0000_0100);
    trap("ecall", TRAP_ENTER, CAUSE_ECALL_MMODE, 32'h0000_0080, 32'h0);
    idle_pc("ecall_redir", 32'h0000_0100);
    idle("ecall_done");
    rd("ecall_mepc", CSR_MEPC, 32'h0000_0080);
    rd("ecall_mcause", CSR_MCAUSE, 32'd11);
    rd("ecall_mstatus", CSR_MSTATUS, 32'h0000_1800);
    csr_acc("rd_minstret", CSR_RW, CSR_MINSTRET, 32'h0, 1'b0, 1'b0, 32'h0);

    // MIE/MPIE round trip through enter and return
    csr_acc("set_mie", CSR_RS, CSR_MSTATUS, 32'h8, 1'b1, 1'b0, 32'h0);
    rd("mie_set", CSR_MSTATUS, 32'h0000_1808);
    trap("brk", TRAP_ENTER, CAUSE_BREAKPOINT, 32'h0000_0082, 32'h0);
    idle_pc("brk_redir", 32'h0000_0100);
    rd("brk_mstatus", CSR_MSTATUS, 32'h0000_1880);
    trap("mret", TRAP_RETURN, 5'd0, 32'h0, 32'h0);
    idle_pc("mret_redir", 32'h0000_0080);
    rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // Trap suppresses a same-cycle CSR write
    csr_acc("wr_mscratch", CSR_RW, CSR_MSCRATCH, 32'h0000_00AA, 1'b1, 1'b0, 32'h0);
    s = blank("ld_misalign"); s.tv = 1; s.md = TRAP_ENTER; s.cause = CAUSE_MISALIGNED_LOAD;
    s.pc = 32'h0000_0200; s.tval = 32'h0000_1003; s.cv = 1; s.we = 1; s.a = CSR_MSCRATCH;
    s.wd = 32'h0000_0055; s.fx = 1; s.fv = 32'h0000_00AA;
    cycle(s);
    idle("ld_redir");
    rd("ld_mtval", CSR_MTVAL, 32'h0000_1003);
    rd("ld_mcause", CSR_MCAUSE, 32'd4);
    rd("ld_mscratch", CSR_MSCRATCH, 32'h0000_00AA);

    // mcycle carry and write-over-increment
    csr_acc("wr_mcycleh0", CSR_RW, CSR_MCYCLEH, 32'h0, 1'b1, 1'b0, 32'h0);
    csr_acc("wr_mcycle", CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    rd("cyc_lo_max", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("cyc_hi_carry", CSR_MCYCLEH, 32'h0000_0001);
    rd("cyc_lo_wrap", CSR_MCYCLE, 32'h0000_0001);
    csr_acc("wr_mcycleh", CSR_RW, CSR_MCYCLEH, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    rd("cyc_lo_hold", CSR_MCYCLE, 32'h0000_0002);
    rd("cyc_hi_wr", CSR_MCYCLEH, 32'h0000_0077);

    // Illegal accesses
    csr_acc("wr_mhartid", CSR_RW, CSR_MHARTID, 32'h123, 1'b1, 1'b0, 32'h0);
    rd("rd_7c0", 12'h7C0, 32'h0);
    rd("rd_mhartid", CSR_MHARTID, HART);

    // Back-to-back trap requests, then reset in the redirect cycle
    trap("b2b_first", TRAP_ENTER, CAUSE_ILLEGAL_INSTR, 32'h0000_0300, 32'h0);
    s = blank("b2b_second"); s.tv = 1; s.cause = CAUSE_MISALIGNED_STORE; s.pc = 32'h400;
    s.fpc = 1; s.fpcv = 32'h0000_0100;
    cycle(s);
    idle("b2b_done");
    rd("b2b_mcause", CSR_MCAUSE, 32'd2);
    trap("rst_trap", TRAP_ENTER, CAUSE_ECALL_MMODE, 32'h0000_0500, 32'h0);
    s = blank("rst_in_redir"); s.rst = 1; cycle(s);
    idle_pc("post_rst", 32'h0);
    rd("post_rst_mstat", CSR_MSTATUS, 32'h0000_1800);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      s = blank("rand");
      s.rst   = ($urandom_range(0, 99) == 0);
      s.tv    = ($urandom_range(0, 9) == 0);
      s.md    = trap_mode_t'($urandom_range(0, 1));
      s.cause = 5'($urandom_range(0, 15));
      s.pc    = $urandom;
      s.tval  = $urandom;
      s.ret   = 1'($urandom_range(0, 1));
      s.cv    = 1'($urandom_range(0, 1));
      s.we    = 1'($urandom_range(0, 1));
      s.op    = csr_op_t'($urandom_range(0, 2));
      s.a     = addrs[$urandom_range(0, 13)];
      s.wd    = $urandom;
      cycle(s);
    end

    idle("drain");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Machine-mode trap responder and CSR file, located at the commit boundary. It consumes the `trap_req_t` packets produced by the execute stage and carried down the pipeline. It captures trap state into `mepc`/`mcause`/`mtval`/`mstatus` and drives a one-cycle PC redirect plus a pipeline flush. It also serves CSR read/modify/write accesses and the `mcycle`/`minstret` counters.

## Interface
- `HART_ID`, default 0: value returned by `mhartid`.
- `MISA_VAL`, default 32'h4000_0100: value returned by `misa` (RV32I).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trap_req`  in  `trap_req_t`  trap packet at commit: `valid`, `mode` (`TRAP_ENTER`/`TRAP_RETURN`), `cause`, `pc`, `tval`.
- `retire`  in  1  one instruction committed this cycle.
- `csr_valid`  in  1  CSR instruction at commit.
- `csr_we`  in  1  write intent; decoder clears it for CSRRS/CSRRC with rs1/uimm = 0.
- `csr_op`  in  `csr_op_t`  `CSR_RW` / `CSR_RS` / `CSR_RC`.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  operand (forwarded rs1 or zero-extended uimm).
- `csr_rdata`  out  32  old CSR value, combinational.
- `csr_illegal`  out  1  access is illegal, combinational.
- `redirect_valid`  out  1  fetch must load `redirect_pc`.
- `redirect_pc`  out  32  trap vector or return address.
- `flush_req`  out  1  flush all stages younger than commit.
- `trap_busy`  out  1  trap sequence in progress.

## Operation
- FSM states `TS_IDLE`, `TS_REDIRECT`.
  - `TS_IDLE` with `trap_req.valid`: go to `TS_REDIRECT`.
  - `TS_REDIRECT`: always return to `TS_IDLE` on the next edge.
- `TRAP_ENTER` accepted in `TS_IDLE`:
  - `mepc` ← `{pc[31:2],2'b00}`.
  - `mcause` ← `{1'b0, zero-extended cause}`.
  - `mtval` ← `tval`.
  - MPIE ← MIE, then MIE ← 0.
  - Latch `redirect_pc` = `{mtvec[31:2],2'b00}` (direct mode only).
- `TRAP_RETURN` accepted in `TS_IDLE`: MIE ← MPIE, MPIE ← 1. Latch `redirect_pc` = `mepc`. `mepc`, `mcause` and `mtval` are unchanged.
- `trap_req.valid` in `TS_REDIRECT` is ignored. It belongs to a flushed instruction.
- CSR map:
  - `mstatus` 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] read 2'b11, all other bits read 0.
  - `misa` 0x301: writes ignored.
  - `mtvec` 0x305: bits [1:0] read 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342, `mtval` 0x343.
  - `mcycle`/`mcycleh` 0xB00/0xB80, `minstret`/`minstreth` 0xB02/0xB82.
  - `mhartid` 0xF14.
- Write value by `csr_op`:
  - `CSR_RW`: `wdata`.
  - `CSR_RS`: `old | wdata`.
  - `CSR_RC`: `old & ~wdata`.
- `csr_illegal` = `csr_valid` & (address unmapped, or (`csr_addr[11:10]==2'b11` & `csr_we`)). An illegal access writes nothing. The decoder/commit logic converts it to an illegal-instruction trap.
- Counters:
  - `mcycle` is a 64-bit counter that increments every cycle.
  - `minstret` is a 64-bit counter that increments when `retire` is high.
  - The carry from the low word propagates into the high word in the same cycle.
  - A CSR write to either half wins over the increment of the whole counter in that cycle.
- Priority: an accepted trap suppresses a same-cycle CSR write. The CSR instruction is younger and is flushed. `minstret` does not count the trapping instruction even if `retire` is high.

## Timing
- Reset values:
  - State `TS_IDLE`.
  - All CSRs 0, including MIE and MPIE.
  - Both counters 0.
  - `redirect_valid`, `flush_req` and `trap_busy` 0.
  - `redirect_pc` 0.
- Trap sampled in cycle N (`TS_IDLE`):
  - `flush_req` = 1 in cycle N, combinational.
  - CSRs update at the end of N.
  - Cycle N+1: `redirect_valid` = 1, `flush_req` = 1, `trap_busy` = 1.
  - Cycle N+2: all three are 0 and a new trap can be accepted.
- `csr_rdata` is zero-latency. A write is visible to a read in the next cycle.
- `rst` asserted in `TS_REDIRECT` returns to `TS_IDLE` on the next edge. No redirect is issued.

## Structure
- Add `csr_op_t`, `trap_state_t`, the `CSR_*` address constants and the mstatus bit positions to `riscv_defines`. `trap_req_t` and the `CAUSE_*` constants already live there.
- Sub-module `csr_counter64` (64-bit counter with increment enable, per-half write enables and carry). Instantiate it twice, for `mcycle` and `minstret`.

## Test plan
- Set `mtvec`=0x0000_0101 via `CSR_RW`, then trap with `TRAP_ENTER`, cause `CAUSE_ECALL_MMODE`, pc 0x80 -> `mtvec` reads 0x100, `redirect_pc` = 0x100 for exactly one cycle, `mepc` = 0x80, `mcause` = 11, MIE = 0, MPIE = old MIE.
- Set MIE = 1, take a trap, then issue `TRAP_RETURN` -> `redirect_pc` = 0x80, MIE = 1, MPIE = 1.
- Misaligned load trap with tval 0x1003 together with a same-cycle CSR write to `mscratch` -> `mtval` = 0x1003, `mcause` = 4, `mscratch` unchanged.
- Write `mcycle` = 0xFFFF_FFFF, then hold -> next cycle `mcycle` = 0, `mcycleh` = 1. A write to `mcycleh` wins over the increment in its cycle.
- `csr_we` = 1 to 0xF14, and a read from 0x7C0 -> `csr_illegal` = 1 for both, no state change. A read of 0xF14 returns `HART_ID`.
- Back-to-back `trap_req.valid` in cycles N and N+1 -> only one redirect. `rst` pulsed in N+1 -> no redirect and all outputs at reset values.
